serial_adder: RTL and testbench



---
 rtl/serial_adder.sv | 95 +++++++++
 tb/tb_serial_adder.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit add/subtract unit: one full-adder slice plus a carry flop,
// LSB first, with a start/busy/done handshake.
module serial_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             ovf
);

    localparam int unsigned CW = $clog2(WIDTH) + 1;

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] ra_q, rb_q, rs_q, rs_d;
    logic [CW-1:0]    cnt_q;
    logic             c_q;
    logic             s_bit, c_out, last;

    assign s_bit = ra_q[0] ^ rb_q[0] ^ c_q;
    assign c_out = (ra_q[0] & rb_q[0]) | (ra_q[0] & c_q) | (rb_q[0] & c_q);
    assign last  = (cnt_q == CW'(WIDTH - 1));
    // New bit enters at the MSB so that after WIDTH shifts the result is aligned.
    assign rs_d  = (rs_q >> 1) | (WIDTH'(s_bit) << (WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (start) state_d = StRun;
            StRun:  if (last)  state_d = StIdle;
        endcase
    end

    always_comb begin
        busy = (state_q == StRun);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ra_q  <= '0;
            rb_q  <= '0;
            rs_q  <= '0;
            cnt_q <= '0;
            c_q   <= 1'b0;
            sum   <= '0;
            carry <= 1'b0;
            ovf   <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        ra_q  <= a;
                        rb_q  <= b ^ {WIDTH{sub}};
                        c_q   <= sub;
                        cnt_q <= '0;
                    end
                end
                StRun: begin
                    ra_q  <= ra_q >> 1;
                    rb_q  <= rb_q >> 1;
                    rs_q  <= rs_d;
                    c_q   <= c_out;
                    cnt_q <= cnt_q + CW'(1);
                    if (last) begin
                        // c_q here is the carry into the MSB (equals sub when WIDTH=1).
                        sum   <= rs_d;
                        carry <= c_out;
                        ovf   <= c_q ^ c_out;
                        done  <= 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Randomised self-checking bench for serial_adder at WIDTH=8 and WIDTH=1,
// compared against a plain-arithmetic reference model.
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       start8 = 1'b0, sub8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       busy8, done8, carry8, ovf8;
    logic [7:0] sum8;

    logic       start1 = 1'b0, sub1 = 1'b0;
    logic [0:0] a1 = '0, b1 = '0;
    logic       busy1, done1, carry1, ovf1;
    logic [0:0] sum1;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] exp_sum8 = '0;
    logic       exp_c8 = 1'b0, exp_o8 = 1'b0;
    logic       exp_sum1 = 1'b0, exp_c1 = 1'b0, exp_o1 = 1'b0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .sub(sub8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .sum(sum8), .carry(carry8), .ovf(ovf8)
    );

    serial_adder #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .sub(sub1), .a(a1), .b(b1),
        .busy(busy1), .done(done1), .sum(sum1), .carry(carry1), .ovf(ovf1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Returns {ovf, carry, sum[7:0]} for a w-bit add (s=0) or subtract (s=1).
    function automatic logic [9:0] ref_op(input int w, input int a, input int b, input int s);
        int mask, bb, tot, res, cy, sa, sb, sr, ov;
        mask = (1 << w) - 1;
        bb   = s ? (~b & mask) : (b & mask);
        tot  = (a & mask) + bb + s;
        res  = tot & mask;
        cy   = (tot >> w) & 1;
        sa   = (a >> (w - 1)) & 1;
        sb   = (b >> (w - 1)) & 1;
        sr   = (res >> (w - 1)) & 1;
        ov   = s ? ((sa != sb) && (sr != sa)) : ((sa == sb) && (sr != sa));
        return {ov[0], cy[0], res[7:0]};
    endfunction

    // Called at a negedge; START is seen at the next posedge (E0).
    task automatic launch8(input logic [7:0] a, input logic [7:0] b, input logic s);
        start8 = 1'b1; a8 = a; b8 = b; sub8 = s;
        @(posedge clk);
        #1 start8 = 1'b0;
    endtask

    task automatic wait_done8(input string tag, input logic [7:0] a, input logic [7:0] b,
                              input logic s, input int inject);
        logic [9:0] r;
        int n = 0;
        bit seen = 0;
        r = ref_op(8, a, b, s);
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (done8) begin
                seen = 1;
            end else begin
                if (busy8) n++;
                check({tag, "-hold"}, {sum8, carry8, ovf8}, {exp_sum8, exp_c8, exp_o8});
                if (i == inject) begin
                    start8 = 1'b1; a8 = 8'hAA; b8 = ~b; sub8 = ~s;
                end else if (i == inject + 1) begin
                    start8 = 1'b0;
                end
            end
        end
        check({tag, "-seen"}, 32'(seen), 32'd1);
        check({tag, "-busycyc"}, n, 32'd8);
        check({tag, "-busy@done"}, 32'(busy8), 32'd0);
        check({tag, "-sum"}, 32'(sum8), 32'(r[7:0]));
        check({tag, "-carry"}, 32'(carry8), 32'(r[8]));
        check({tag, "-ovf"}, 32'(ovf8), 32'(r[9]));
        exp_sum8 = r[7:0]; exp_c8 = r[8]; exp_o8 = r[9];
    endtask

    task automatic op8(input string tag, input logic [7:0] a, input logic [7:0] b, input logic s);
        @(negedge clk);
        launch8(a, b, s);
        wait_done8(tag, a, b, s, -1);
        @(negedge clk);
        check({tag, "-pulse"}, 32'(done8), 32'd0);
    endtask

    task automatic op1(input string tag, input logic a, input logic b, input logic s);
        logic [9:0] r;
        int n = 0;
        bit seen = 0;
        r = ref_op(1, a, b, s);
        @(negedge clk);
        start1 = 1'b1; a1 = a; b1 = b; sub1 = s;
        @(posedge clk);
        #1 start1 = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (done1) seen = 1;
            else if (busy1) n++;
        end
        check({tag, "-seen"}, 32'(seen), 32'd1);
        check({tag, "-busycyc"}, n, 32'd1);
        check({tag, "-sum"}, 32'(sum1), 32'(r[0]));
        check({tag, "-carry"}, 32'(carry1), 32'(r[8]));
        check({tag, "-ovf"}, 32'(ovf1), 32'(r[9]));
    endtask

    initial begin
        logic [7:0] ra, rb;
        logic       rs;
        #12;
        check("rst-busy", 32'(busy8), 32'd0);
        check("rst-done", 32'(done8), 32'd0);
        check("rst-out8", {sum8, carry8, ovf8}, 32'd0);
        check("rst-out1", {sum1, carry1, ovf1}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        op8("add0f01", 8'h0F, 8'h01, 1'b0);
        op8("addff01", 8'hFF, 8'h01, 1'b0);
        op8("add7f01", 8'h7F, 8'h01, 1'b0);
        op8("sub0507", 8'h05, 8'h07, 1'b1);
        op8("sub8001", 8'h80, 8'h01, 1'b1);

        // START during RUN ignored, then back-to-back START in the DONE cycle.
        @(negedge clk);
        launch8(8'h33, 8'h11, 1'b0);
        wait_done8("ignore", 8'h33, 8'h11, 1'b0, 2);
        launch8(8'h01, 8'h02, 1'b0);
        wait_done8("b2b", 8'h01, 8'h02, 1'b0, -1);

        // Reset mid-RUN aborts the operation.
        @(negedge clk);
        launch8(8'h12, 8'h34, 1'b0);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort-busy", 32'(busy8), 32'd0);
        check("abort-done", 32'(done8), 32'd0);
        check("abort-out", {sum8, carry8, ovf8}, 32'd0);
        exp_sum8 = '0; exp_c8 = 1'b0; exp_o8 = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("abort-nodone", {busy8, done8}, 32'd0);
        end
        op8("postrst", 8'h40, 8'h40, 1'b0);

        for (int k = 0; k < 30; k++) begin
            ra = 8'($urandom); rb = 8'($urandom); rs = 1'($urandom);
            if (k % 3 == 0) begin
                launch8(ra, rb, rs);
                wait_done8("rand-b2b", ra, rb, rs, -1);
            end else begin
                op8("rand", ra, rb, rs);
            end
        end

        for (int k = 0; k < 8; k++) begin
            op1("w1", k[0], k[1], k[2]);
        end

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
